// File: rtl/addsub_pkg.sv
// Shared op encoding for the segmented add/subtract pipeline.
package addsub_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

endpackage

// File: rtl/addsub_seg.sv
// One carry-chain segment: SEG-bit add, result/carry/valid registered in 1 cycle.
// Holds every register while i_en is low; reset clears all state.
module addsub_seg #(
    parameter int SEG = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_en,
    input  logic           i_vld,
    input  logic [SEG-1:0] i_a,
    input  logic [SEG-1:0] i_b,
    input  logic           i_c,
    output logic           o_vld,
    output logic [SEG-1:0] o_sum,
    output logic           o_co,
    output logic           o_cmsb
);

    logic [SEG:0] w_add;
    logic         w_cmsb;

    assign w_add  = {1'b0, i_a} + {1'b0, i_b} + {{SEG{1'b0}}, i_c};
    // carry into the segment MSB recovered from its sum bit; valid for SEG=1 too
    assign w_cmsb = w_add[SEG-1] ^ i_a[SEG-1] ^ i_b[SEG-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            o_vld  <= 1'b0;
            o_sum  <= '0;
            o_co   <= 1'b0;
            o_cmsb <= 1'b0;
        end else if (i_en) begin
            o_vld  <= i_vld;
            o_sum  <= w_add[SEG-1:0];
            o_co   <= w_add[SEG];
            o_cmsb <= w_cmsb;
        end
    end

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract, carry chain split into WIDTH/SEG stages; latency WIDTH/SEG cycles.
// Whole pipe holds when out_valid && !out_ready; PIPE_ADDSUB_SAT_EN adds signed saturation.
module pipe_addsub #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    import addsub_pkg::*;

    localparam int N = WIDTH / SEG;

    logic             w_en;
    logic [WIDTH-1:0] w_bx;
    logic             w_c0;

    logic [N-1:0]     w_vi, w_ci, w_vo, w_co, w_cmsb;
    logic [WIDTH-1:0] w_ai [N];
    logic [WIDTH-1:0] w_bi [N];
    logic [WIDTH-1:0] w_si [N];
    logic [WIDTH-1:0] w_so [N];
    logic [SEG-1:0]   w_seg [N];

    // operands still to be added and sum bits already produced, one word per stage
    logic [WIDTH-1:0] r_a [N];
    logic [WIDTH-1:0] r_b [N];
    logic [WIDTH-1:0] r_s [N];

    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf;

    assign w_en = !out_valid || out_ready;
    assign w_bx = (op == OP_SUB) ? ~b : b;
    assign w_c0 = (op == OP_SUB) ? 1'b1 : cin;

    for (genvar k = 0; k < N; k++) begin : g_stg
        if (k == 0) begin : g_first
            assign w_vi[k] = in_valid;
            assign w_ci[k] = w_c0;
            assign w_ai[k] = a;
            assign w_bi[k] = w_bx;
            assign w_si[k] = '0;
        end else begin : g_next
            assign w_vi[k] = w_vo[k-1];
            assign w_ci[k] = w_co[k-1];
            assign w_ai[k] = r_a[k-1];
            assign w_bi[k] = r_b[k-1];
            assign w_si[k] = w_so[k-1];
        end

        addsub_seg #(
            .SEG(SEG)
        ) u_seg (
            .clk    (clk),
            .reset  (reset),
            .i_en   (w_en),
            .i_vld  (w_vi[k]),
            .i_a    (w_ai[k][k*SEG +: SEG]),
            .i_b    (w_bi[k][k*SEG +: SEG]),
            .i_c    (w_ci[k]),
            .o_vld  (w_vo[k]),
            .o_sum  (w_seg[k]),
            .o_co   (w_co[k]),
            .o_cmsb (w_cmsb[k])
        );

        // r_s[k] only carries bits below segment k, so the new segment can be OR-ed in
        assign w_so[k] = r_s[k] | (WIDTH'(w_seg[k]) << (k*SEG));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
            end
        end else if (w_en) begin
            for (int k = 0; k < N; k++) begin
                r_a[k] <= w_ai[k];
                r_b[k] <= w_bi[k];
                r_s[k] <= w_si[k];
            end
        end
    end

    assign w_raw  = w_so[N-1];
    assign w_cout = w_co[N-1];
    assign w_ovf  = w_cmsb[N-1] ^ w_cout;

`ifdef PIPE_ADDSUB_SAT_EN
    // a wrapped negative-looking result means the true value overflowed positive
    always_comb begin
        w_sum = w_raw;
        if (w_ovf) begin
            w_sum = w_raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
        end
    end
`else
    assign w_sum = w_raw;
`endif

    assign in_ready  = w_en;
    assign out_valid = w_vo[N-1];
    assign sum       = w_sum;
    assign cout      = w_cout;
    assign ovf       = w_ovf;
    assign zero      = out_valid && (w_sum == '0);

endmodule

// File: tb/tb_pipe_addsub.sv
// Scoreboard bench for pipe_addsub: 16/4 pipelined instance and 32/32 single-stage instance.
module tb_pipe_addsub;

    import addsub_pkg::*;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, sum;
    logic        cin, op, cout, ovf, zero;

    logic        in_valid32, in_ready32, out_valid32, out_ready32;
    logic [31:0] a32, b32, sum32;
    logic        cin32, op32, cout32, ovf32, zero32;

    pipe_addsub #(.WIDTH(16), .SEG(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    pipe_addsub #(.WIDTH(32), .SEG(32)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .cin(cin32), .op(op32), .out_valid(out_valid32), .out_ready(out_ready32),
        .sum(sum32), .cout(cout32), .ovf(ovf32), .zero(zero32)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_out16  = 0;
    int   n_out32  = 0;
    res_t q16[$];
    res_t q32[$];
    res_t e16, e32;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // reference: signed overflow from operand/result signs, carry from a wide sum
    function automatic res_t model(input int w, input logic [31:0] x, input logic [31:0] y,
                                   input logic c, input logic o);
        logic [63:0] m, yb, t;
        logic        sx, sy, ss;
        res_t        r;
        m      = (64'd1 << w) - 64'd1;
        yb     = (o ? ~{32'b0, y} : {32'b0, y}) & m;
        t      = ({32'b0, x} & m) + yb + {63'b0, (o ? 1'b1 : c)};
        r.sum  = 32'(t & m);
        r.cout = t[w];
        sx     = x[w-1];
        sy     = yb[w-1];
        ss     = r.sum[w-1];
        r.ovf  = (sx == sy) && (ss != sx);
`ifdef PIPE_ADDSUB_SAT_EN
        if (r.ovf) r.sum = sx ? 32'(64'd1 << (w-1)) : 32'(m >> 1);
`endif
        r.zero = (r.sum == 32'd0);
        return r;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            q16.delete();
            q32.delete();
        end else begin
            if (in_valid && in_ready) q16.push_back(model(16, {16'b0, a}, {16'b0, b}, cin, op));
            if (out_valid && out_ready) begin
                n_out16++;
                if (q16.size() == 0) chk("sb16_unexpected_output", 1, 0);
                else begin
                    e16 = q16.pop_front();
                    chk("sb16_sum", sum, e16.sum);
                    chk("sb16_cout", cout, e16.cout);
                    chk("sb16_ovf", ovf, e16.ovf);
                    chk("sb16_zero", zero, e16.zero);
                end
            end
            if (in_valid32 && in_ready32) q32.push_back(model(32, a32, b32, cin32, op32));
            if (out_valid32 && out_ready32) begin
                n_out32++;
                if (q32.size() == 0) chk("sb32_unexpected_output", 1, 0);
                else begin
                    e32 = q32.pop_front();
                    chk("sb32_sum", sum32, e32.sum);
                    chk("sb32_cout", cout32, e32.cout);
                    chk("sb32_ovf", ovf32, e32.ovf);
                    chk("sb32_zero", zero32, e32.zero);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // offer one transaction to the idle 16-bit pipe, return edges until out_valid
    task automatic single16(input logic [15:0] x, input logic [15:0] y, input logic c,
                            input logic o, output int lat);
        a = x; b = y; cin = c; op = o; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int          lat, idx, start, stray;
        logic        fire, hold_prev;
        logic [18:0] held;
        logic [15:0] va [8];
        logic [15:0] vb [8];
        logic        vo [8];

        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op = OP_ADD; out_ready = 1'b1;
        in_valid32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; op32 = OP_ADD; out_ready32 = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sum_flags", {sum, cout, ovf, zero}, 0);
        chk("rst_out_valid32", out_valid32, 0);
        tick();

        single16(16'h00FF, 16'h0001, 1'b0, OP_ADD, lat);
        chk("add_latency", lat, 4);
        chk("add_sum", sum, 16'h0100);
        chk("add_cout_ovf", {cout, ovf}, 2'b00);
        tick();

        single16(16'h8000, 16'h0001, 1'b0, OP_SUB, lat);
        chk("sub_latency", lat, 4);
`ifdef PIPE_ADDSUB_SAT_EN
        chk("sub_ovf_sum", sum, 16'h8000);
`else
        chk("sub_ovf_sum", sum, 16'h7FFF);
`endif
        chk("sub_ovf_cout", cout, 1);
        chk("sub_ovf_flag", ovf, 1);
        tick();

        single16(16'hFFFF, 16'h0000, 1'b1, OP_ADD, lat);
        chk("wrap_sum", sum, 16'h0000);
        chk("wrap_cout_zero_ovf", {cout, zero, ovf}, 3'b110);
        tick();

        single16(16'h0005, 16'h0003, 1'b0, OP_SUB, lat);
        chk("sub_ignores_cin", sum, 16'h0002);
        tick();

        // 8 back-to-back transactions, downstream stalled in cycles 5..7
        for (int i = 0; i < 8; i++) begin
            va[i] = 16'($urandom);
            vb[i] = 16'($urandom);
            vo[i] = i[0];
        end
        idx = 0; hold_prev = 1'b0; held = '0; start = n_out16;
        for (int c = 0; c < 40; c++) begin
            in_valid = (idx < 8);
            if (idx < 8) begin a = va[idx]; b = vb[idx]; op = vo[idx]; cin = 1'b1; end
            out_ready = !(c >= 5 && c <= 7);
            @(negedge clk);
            if (!out_ready) begin
                chk("stall_out_valid", out_valid, 1);
                chk("stall_in_ready", in_ready, 0);
                if (hold_prev) chk("stall_outputs_held", {sum, cout, ovf, zero}, held);
                held = {sum, cout, ovf, zero};
                hold_prev = 1'b1;
            end else hold_prev = 1'b0;
            fire = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (fire) idx++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stall_delivered", n_out16 - start, 8);
        chk("stall_queue_empty", q16.size(), 0);

        // three in flight, then reset with a fresh offer that must be dropped
        for (int i = 0; i < 3; i++) begin
            a = 16'h0100 * 16'(i + 1); b = 16'h0011; op = OP_ADD; cin = 1'b0; in_valid = 1'b1;
            tick();
        end
        a = 16'h1234; reset = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_sum_flags", {sum, cout, ovf, zero}, 0);
        stray = 0;
        repeat (12) begin
            tick();
            @(negedge clk);
            if (out_valid) stray++;
        end
        chk("midrst_no_stale", stray, 0);
        tick();

        // single-stage instance: latency 1, then random traffic with backpressure
        a32 = 32'h7FFF_FFFF; b32 = 32'h0000_0001; cin32 = 1'b0; op32 = OP_ADD; in_valid32 = 1'b1;
        tick();
        in_valid32 = 1'b0;
        @(negedge clk);
        chk("lat32_valid", out_valid32, 1);
        chk("lat32_ovf", ovf32, 1);
        tick();
        start = n_out32; idx = 0;
        a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom); op32 = 1'($urandom);
        for (int c = 0; c < 200 && idx < 24; c++) begin
            in_valid32  = 1'b1;
            out_ready32 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            fire = in_valid32 && in_ready32;
            @(posedge clk);
            #1;
            if (fire) begin
                idx++;
                a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom); op32 = 1'($urandom);
            end
        end
        in_valid32 = 1'b0; out_ready32 = 1'b1;
        repeat (5) tick();
        chk("rand32_accepted", idx, 24);
        chk("rand32_delivered", n_out32 - start, 24);
        chk("rand32_queue_empty", q32.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
